// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit for the datapath.
// Runs fetch T0-T2, then an opcode-specific execute sequence T3-T7.
// Memory steps wait for mem_ready, guarded by a wait-timeout counter.
// Control strobes decode from state and ir[31:27]; mem_fault/illegal are sticky flags.
//
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN
//   defined   : an undefined opcode in T3 halts the sequencer and sets illegal
//   undefined : an undefined opcode executes as nop; illegal is tied 0
//
// Ports:
//   clk, reset_n                 clock (rising edge), async active-low reset
//   ir[31:0], con_ff, mem_ready  instruction, branch condition, memory completion
//   Gra/Grb/Grc, r_in/r_out/ba_out          register select / encode strobes
//   pc_out/pc_in/inc_pc, mar_in/mdr_in/mdr_out/ir_in, read/write   PC, MAR/MDR/IR, memory
//   y_in/z_in/z_low_out/c_out/con_in, alu_op                       ALU controls
//   running, mem_fault, illegal  status
module control_sequencer #(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned ALU_OP_W     = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [31:0]         ir,
  input  logic                con_ff,
  input  logic                mem_ready,
  output logic                Gra,
  output logic                Grb,
  output logic                Grc,
  output logic                r_in,
  output logic                r_out,
  output logic                ba_out,
  output logic                pc_out,
  output logic                pc_in,
  output logic                inc_pc,
  output logic                mar_in,
  output logic                mdr_in,
  output logic                mdr_out,
  output logic                ir_in,
  output logic                read,
  output logic                write,
  output logic                y_in,
  output logic                z_in,
  output logic                z_low_out,
  output logic                c_out,
  output logic                con_in,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                running,
  output logic                mem_fault,
  output logic                illegal
);

  localparam int unsigned CNT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_ANDI = 5'd13;
  localparam logic [4:0] OP_ORI  = 5'd14;
  localparam logic [4:0] OP_BR   = 5'd19;
  localparam logic [4:0] OP_HALT = 5'd27;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(3);

  typedef enum logic [3:0] {
    ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mem_fault_d;
  logic               hold;
  state_t             hold_next;
  logic [ALU_OP_W-1:0] alu_sel;

  logic [4:0] op;
  logic       is_alu, is_imm, is_ldi, is_ld, is_st, is_br, is_halt;
  logic       ir_unused_c;

  assign op          = ir[31:27];
  assign ir_unused_c = ^ir[26:0];

  // Opcode class decode
  assign is_alu  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  assign is_imm  = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  assign is_ldi  = (op == OP_LDI);
  assign is_ld   = (op == OP_LD);
  assign is_st   = (op == OP_ST);
  assign is_br   = (op == OP_BR);
  assign is_halt = (op == OP_HALT);

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic is_known;
  logic illegal_d;
  assign is_known = is_alu || is_imm || is_ldi || is_ld || is_st || is_br || is_halt ||
                    (op == 5'd26);
`endif

  // ALU operation selected by the opcode (register and immediate forms)
  always_comb begin
    alu_sel = ALU_ADD;
    case (op)
      OP_SUB:          alu_sel = ALU_SUB;
      OP_AND, OP_ANDI: alu_sel = ALU_AND;
      OP_OR,  OP_ORI:  alu_sel = ALU_OR;
      default:         alu_sel = ALU_ADD;
    endcase
  end

  // State, wait counter and sticky flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_RST;
      cnt_q     <= '0;
      mem_fault <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_fault <= mem_fault_d;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) illegal <= 1'b0;
    else          illegal <= illegal_d;
  end
`else
  assign illegal = 1'b0;
`endif

  // Next-state and Moore output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    mem_fault_d = mem_fault;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_d   = illegal;
`endif
    hold        = 1'b0;
    hold_next   = ST_T0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    r_in = 1'b0; r_out = 1'b0; ba_out = 1'b0;
    pc_out = 1'b0; pc_in = 1'b0; inc_pc = 1'b0;
    mar_in = 1'b0; mdr_in = 1'b0; mdr_out = 1'b0; ir_in = 1'b0;
    read = 1'b0; write = 1'b0;
    y_in = 1'b0; z_in = 1'b0; z_low_out = 1'b0; c_out = 1'b0; con_in = 1'b0;
    alu_op  = ALU_ADD;
    running = (state_q != ST_RST) && (state_q != ST_HALT);

    case (state_q)
      ST_RST: state_d = ST_T0;
      ST_T0: begin
        pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
        state_d = ST_T1;
      end
      ST_T1: begin
        z_low_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1;
        hold = 1'b1; hold_next = ST_T2;
      end
      ST_T2: begin
        mdr_out = 1'b1; ir_in = 1'b1;
        state_d = ST_T3;
      end
      ST_T3: begin
        if (is_alu || is_imm) begin
          Grb = 1'b1; r_out = 1'b1; y_in = 1'b1; ba_out = is_imm;
          state_d = ST_T4;
        end else if (is_ldi || is_ld || is_st) begin
          Grb = 1'b1; ba_out = 1'b1; y_in = 1'b1;
          state_d = ST_T4;
        end else if (is_br) begin
          Gra = 1'b1; r_out = 1'b1; con_in = 1'b1;
          state_d = ST_T4;
        end else if (is_halt) begin
          state_d = ST_HALT;
        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          if (!is_known) begin
            state_d   = ST_HALT;
            illegal_d = 1'b1;
          end else begin
            state_d = ST_T0;
          end
`else
          state_d = ST_T0;
`endif
        end
      end
      ST_T4: begin
        state_d = ST_T5;
        if (is_alu) begin
          Grc = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = alu_sel;
        end else if (is_imm) begin
          c_out = 1'b1; z_in = 1'b1; alu_op = alu_sel;
        end else if (is_ldi || is_ld || is_st) begin
          c_out = 1'b1; z_in = 1'b1;
        end else if (is_br) begin
          pc_out = 1'b1; y_in = 1'b1;
        end else begin
          state_d = ST_T0;
        end
      end
      ST_T5: begin
        state_d = ST_T0;
        if (is_alu || is_imm || is_ldi) begin
          z_low_out = 1'b1; Gra = 1'b1; r_in = 1'b1;
        end else if (is_ld || is_st) begin
          z_low_out = 1'b1; mar_in = 1'b1;
          state_d = ST_T6;
        end else if (is_br) begin
          c_out = 1'b1; z_in = 1'b1;
          state_d = ST_T6;
        end
      end
      ST_T6: begin
        state_d = ST_T0;
        if (is_ld) begin
          read = 1'b1; mdr_in = 1'b1;
          hold = 1'b1; hold_next = ST_T7;
        end else if (is_st) begin
          Gra = 1'b1; r_out = 1'b1; mdr_in = 1'b1;
          state_d = ST_T7;
        end else if (is_br) begin
          z_low_out = con_ff; pc_in = con_ff;
        end
      end
      ST_T7: begin
        state_d = ST_T0;
        if (is_ld) begin
          mdr_out = 1'b1; Gra = 1'b1; r_in = 1'b1;
        end else if (is_st) begin
          write = 1'b1;
          hold = 1'b1; hold_next = ST_T0;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RST;
    endcase

    // Memory hold: advance on mem_ready (wins over timeout), else count or fault
    if (hold) begin
      if (mem_ready) begin
        state_d = hold_next;
      end else if ((MEM_WAIT_MAX != 0) && (cnt_q == CNT_W'(MEM_WAIT_MAX))) begin
        state_d     = ST_HALT;
        mem_fault_d = 1'b1;
      end else begin
        state_d = state_q;
        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
      end
    end
  end

endmodule
